fp_mul_pipe: RTL

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fp_mul_pipe.sv
// Pipelined multi-format mantissa multiplier.
// Each operation is split into lanes according to CONFIG_FP. Every lane
// mantissa product is normalised to one leading bit and packed, left-aligned,
// into OUT, with one normalisation flag per lane. Results travel through a
// STAGES-deep pipeline with a valid/ready handshake on both sides.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   IN_VALID/IN_READY   input handshake; IN1, IN2, CONFIG_FP, IN_TAG payload
//   OUT_VALID/OUT_READY output handshake; OUT, OUT_NormBits, OUT_TAG,
//                       OUT_ILLEGAL payload
//   BUSY                high while any operation is in flight

`ifndef CONFIG_WIDTH
`define CONFIG_WIDTH 3
`endif
`ifndef CONFIG_FP32
`define CONFIG_FP32     3'd0
`define CONFIG_FP16     3'd1
`define CONFIG_TF32     3'd2
`define CONFIG_BF16     3'd3
`define CONFIG_FP8_E4M3 3'd4
`define CONFIG_FP8_E5M2 3'd5
`endif

module fp_mul_pipe #(
  parameter int unsigned STAGES = 3,   // 1..4
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned WIDTH  = 24   // only 24 is supported
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WIDTH-1:0]         IN1,
  input  logic [WIDTH-1:0]         IN2,
  input  logic [`CONFIG_WIDTH-1:0] CONFIG_FP,
  input  logic [TAG_W-1:0]         IN_TAG,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         OUT,
  output logic [3:0]               OUT_NormBits,
  output logic [TAG_W-1:0]         OUT_TAG,
  output logic                     OUT_ILLEGAL,
  output logic                     BUSY
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(STAGES + 1);

  // Per-format lane products
  logic [PW-1:0]      w_p24;
  logic [1:0][21:0]   w_p11;
  logic [15:0]        w_p8;
  logic [3:0][7:0]    w_p4;
  logic [3:0][5:0]    w_p3;

  always_comb begin : products
    w_p24 = PW'(IN1) * PW'(IN2);
    w_p8  = 16'(IN1[7:0]) * 16'(IN2[7:0]);
    for (int i = 0; i < 2; i++) begin
      w_p11[i] = 22'(IN1[12*i +: 11]) * 22'(IN2[12*i +: 11]);
    end
    for (int i = 0; i < 4; i++) begin
      w_p4[i] = 8'(IN1[6*i +: 4]) * 8'(IN2[6*i +: 4]);
      w_p3[i] = 6'(IN1[6*i +: 3]) * 6'(IN2[6*i +: 3]);
    end
  end

  // Product bits below every kept window never reach the output
  logic w_unused;
  assign w_unused = ^{w_p24[PW-WIDTH-2:0], w_p11[1][9:0], w_p11[0][9:0],
                      w_p8[6:0], w_p4[3][2:0], w_p4[2][2:0], w_p4[1][2:0],
                      w_p4[0][2:0], w_p3[3][1:0], w_p3[2][1:0], w_p3[1][1:0],
                      w_p3[0][1:0]};

  // Normalise and place each lane; unsupported codes yield an all-zero result
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_nrm;
  logic             w_ill;

  always_comb begin : format_select
    w_res = '0;
    w_nrm = '0;
    w_ill = 1'b0;
    case (CONFIG_FP)
      `CONFIG_FP32: begin
        w_nrm[0] = w_p24[PW-1];
        w_res    = w_p24[PW-1] ? w_p24[PW-1 -: WIDTH] : w_p24[PW-2 -: WIDTH];
      end
      `CONFIG_FP16, `CONFIG_TF32: begin
        for (int i = 0; i < 2; i++) begin
          w_nrm[i]              = w_p11[i][21];
          w_res[12*i+11 -: 11]  = w_p11[i][21] ? w_p11[i][21:11] : w_p11[i][20:10];
        end
      end
      `CONFIG_BF16: begin
        w_nrm[0]    = w_p8[15];
        w_res[11:4] = w_p8[15] ? w_p8[15:8] : w_p8[14:7];
      end
      `CONFIG_FP8_E4M3: begin
        for (int i = 0; i < 4; i++) begin
          w_nrm[i]            = w_p4[i][7];
          w_res[6*i+5 -: 4]   = w_p4[i][7] ? w_p4[i][7:4] : w_p4[i][6:3];
        end
      end
      `CONFIG_FP8_E5M2: begin
        for (int i = 0; i < 4; i++) begin
          w_nrm[i]            = w_p3[i][5];
          w_res[6*i+5 -: 3]   = w_p3[i][5] ? w_p3[i][5:3] : w_p3[i][4:2];
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Whole pipeline advances together whenever the output slot can move
  logic w_advance;
  logic w_accept;
  logic w_retire;

  assign w_advance = !OUT_VALID || OUT_READY;
  assign w_accept  = IN_VALID && w_advance;
  assign w_retire  = OUT_VALID && OUT_READY;
  assign IN_READY  = w_advance;

  logic [STAGES-1:0]            r_vld;
  logic [STAGES-1:0][WIDTH-1:0] r_dat;
  logic [STAGES-1:0][3:0]       r_nrm;
  logic [STAGES-1:0][TAG_W-1:0] r_tag;
  logic [STAGES-1:0]            r_ill;

  // Pipeline stages; bubbles carry an all-zero payload
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld <= '0;
      r_dat <= '0;
      r_nrm <= '0;
      r_tag <= '0;
      r_ill <= '0;
    end else if (w_advance) begin
      r_vld[0] <= IN_VALID;
      r_dat[0] <= IN_VALID ? w_res  : '0;
      r_nrm[0] <= IN_VALID ? w_nrm  : '0;
      r_tag[0] <= IN_VALID ? IN_TAG : '0;
      r_ill[0] <= IN_VALID && w_ill;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_dat[k] <= r_dat[k-1];
        r_nrm[k] <= r_nrm[k-1];
        r_tag[k] <= r_tag[k-1];
        r_ill[k] <= r_ill[k-1];
      end
    end
  end

  // In-flight operation count
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign OUT_VALID    = r_vld[STAGES-1];
  assign OUT          = r_dat[STAGES-1];
  assign OUT_NormBits = r_nrm[STAGES-1];
  assign OUT_TAG      = r_tag[STAGES-1];
  assign OUT_ILLEGAL  = r_ill[STAGES-1];
  assign BUSY         = (r_cnt != '0);

endmodule
